// File: rtl/latch_bank_ctrl_pkg.sv
// latch_bank_ctrl_pkg: shared FSM state type, counter width and index-width helper
package latch_bank_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_e;
  localparam int CNT_W = 4;
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/latch_bank_ctrl_arb.sv
// rr_arbiter: round-robin arbiter from ptr_i; LATCH_BANK_CTRL_FIXED_PRIO_EN makes lowest index win
module rr_arbiter
  import latch_bank_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [idx_w(NUM_REQ)-1:0]  ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [idx_w(NUM_REQ)-1:0]  idx_o
);
  localparam int IW = idx_w(NUM_REQ);
  // scan from farthest to nearest candidate so the nearest valid one is written last
  always_comb begin
    idx_o = '0;
`ifdef LATCH_BANK_CTRL_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) idx_o = req_i[i] ? IW'(i) : idx_o;
`else
    for (int i = NUM_REQ - 1; i >= 0; i--)
      idx_o = req_i[(int'(ptr_i) + i) % NUM_REQ] ? IW'((int'(ptr_i) + i) % NUM_REQ) : idx_o;
`endif
    gnt_o = (|req_i) ? (NUM_REQ'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/latch_bank_ctrl.sv
// latch_bank_ctrl: sequences glitch-free writes into a latch bank; LATCH_BANK_CTRL_FIXED_PRIO_EN selects fixed priority
module latch_bank_ctrl
  import latch_bank_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int NUM_LAT     = 8,
  parameter int DATA_W      = 8,
  parameter int OPEN_CYCLES = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*$clog2(NUM_LAT)-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]          req_data,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [DATA_W-1:0]                  lat_data_out,
  output logic [NUM_LAT-1:0]                 lat_en_out,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id_out,
  output logic                               busy_out
);
  localparam int AW    = idx_w(NUM_LAT);
  localparam int IW    = idx_w(NUM_REQ);
  localparam int DEC_W = 1 << AW;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      addr_q;
  logic [DATA_W-1:0]  data_q;
  logic [IW-1:0]      gid_q, ptr_q, win_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_LAT-1:0] en_q;
  logic [DEC_W-1:0]   dec;
  logic               accept;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx)
  );
  assign accept = (state_q == IDLE) && (|gnt);
  // out-of-range addresses decode above NUM_LAT and are cut off by the slice
  assign dec = DEC_W'(1) << addr_q;
  // state and open-cycle counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // next-state: IDLE -> SETUP -> OPEN (OPEN_CYCLES) -> HOLD -> IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  state_d = accept ? SETUP : IDLE;
      SETUP: begin
        state_d = OPEN;
        cnt_d   = CNT_W'(OPEN_CYCLES - 1);
      end
      OPEN: begin
        state_d = (cnt_q == '0) ? HOLD : OPEN;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      end
      HOLD:  state_d = IDLE;
    endcase
  end
  // outputs decoded from the current state
  always_comb begin
    req_ready = (state_q == IDLE) ? gnt : '0;
    busy_out  = state_q != IDLE;
  end
  // capture the winning request; data stays on the bus until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
      gid_q  <= '0;
    end else if (accept) begin
      addr_q <= req_addr[int'(win_idx)*AW +: AW];
      data_q <= req_data[int'(win_idx)*DATA_W +: DATA_W];
      gid_q  <= win_idx;
    end
  end
  // enable is registered from the next state so it only rises after SETUP and falls before HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_q <= '0;
    else        en_q <= (state_d == OPEN) ? dec[NUM_LAT-1:0] : '0;
  end
`ifdef LATCH_BANK_CTRL_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  // round-robin pointer moves past the last winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr_q <= '0;
    else if (accept) ptr_q <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
  end
`endif
  assign lat_data_out = data_q;
  assign lat_en_out   = en_q;
  assign grant_id_out = gid_q;
endmodule

// File: tb/tb_latch_bank_ctrl.sv
// tb_latch_bank_ctrl: randomized bench with a transaction-timing reference model over two configurations
module tb_latch_bank_ctrl;
  localparam int NR = 4, DW = 8, AW = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    rdy_a, rdy_b;
  logic [DW-1:0]    dat_a, dat_b;
  logic [7:0]       en_a;
  logic [5:0]       en_b;
  logic [1:0]       gid_a, gid_b;
  logic             busy_a, busy_b;
  latch_bank_ctrl #(.NUM_REQ(NR), .NUM_LAT(8), .DATA_W(DW), .OPEN_CYCLES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(rdy_a), .lat_data_out(dat_a), .lat_en_out(en_a), .grant_id_out(gid_a), .busy_out(busy_a));
  latch_bank_ctrl #(.NUM_REQ(NR), .NUM_LAT(6), .DATA_W(DW), .OPEN_CYCLES(3)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(rdy_b), .lat_data_out(dat_b), .lat_en_out(en_b), .grant_id_out(gid_b), .busy_out(busy_b));
  int sel, nl, oc;
  int t, m_addr, m_data, m_gid, m_ptr, acc;
  int n_checks = 0, n_errors = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d cfg=%0d)", tag, got, exp, t, sel);
    end
  endtask
  function automatic int win(logic [NR-1:0] v, int p);
`ifdef LATCH_BANK_CTRL_FIXED_PRIO_EN
    for (int k = 0; k < NR; k++) if (v[k]) return k;
`else
    for (int k = 0; k < NR; k++) if (v[(p + k) % NR]) return (p + k) % NR;
`endif
    return -1;
  endfunction
  function automatic logic [31:0] o_en();
    return sel ? 32'(en_b) : 32'(en_a);
  endfunction
  function automatic logic [31:0] o_dat();
    return sel ? 32'(dat_b) : 32'(dat_a);
  endfunction
  function automatic logic [31:0] o_busy();
    return sel ? 32'(busy_b) : 32'(busy_a);
  endfunction
  task automatic model_reset();
    t = 0; m_addr = 0; m_data = 0; m_gid = 0; m_ptr = 0;
  endtask
  task automatic set_req(int i, logic v, int a, int d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = AW'(a);
    req_data[i*DW +: DW] = DW'(d);
  endtask
  // t counts cycles since accept: 1 setup, 2..oc+1 open, oc+2 hold
  task automatic tick();
    int w;
    logic [31:0] e_en;
    #1;
    w = win(req_valid, m_ptr);
    e_en = (t >= 2 && t <= oc + 1 && m_addr < nl) ? (32'd1 << m_addr) : 32'd0;
    check("ready", sel ? 32'(rdy_b) : 32'(rdy_a), (t == 0 && w >= 0) ? (32'd1 << w) : 32'd0);
    check("busy", o_busy(), 32'(t != 0));
    check("lat_en", o_en(), e_en);
    check("en_onehot", 32'($countones(o_en()) <= 1), 32'd1);
    check("data", o_dat(), 32'(m_data));
    check("grant_id", sel ? 32'(gid_b) : 32'(gid_a), 32'(m_gid));
    @(posedge clk);
    acc = -1;
    if (t == 0) begin
      if (w >= 0 && rst_n) begin
        m_addr = int'(req_addr[w*AW +: AW]);
        m_data = int'(req_data[w*DW +: DW]);
        m_gid = w; m_ptr = (w + 1) % NR; t = 1; acc = w;
      end
    end else t = (t == oc + 2) ? 0 : t + 1;
    #1;
  endtask
  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask
  task automatic rand_run(int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NR; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) set_req(i, 1'b1, $urandom_range(0, 7), int'($urandom_range(0, 255)));
      tick();
      if (acc >= 0) req_valid[acc] = 1'b0;
    end
  endtask
  task automatic all_valid(int n);
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 2 * i + 1, int'($urandom_range(0, 255)));
    for (int c = 0; c < n; c++) begin
      tick();
      if (acc >= 0) set_req(acc, 1'b1, 2 * acc + 1, int'($urandom_range(0, 255)));
    end
    req_valid = '0;
  endtask
  initial begin
    req_valid = '0; req_addr = '0; req_data = '0;
    sel = 0; nl = 8; oc = 1;
    do_reset();
    set_req(0, 1'b1, 3, 'hA5);
    tick();
    req_valid = '0;
    for (int c = 0; c < 5; c++) tick();
    set_req(2, 1'b1, 4, 'h5A);
    tick();
    req_valid = '0;
    tick();
    check("en_pre_reset", o_en(), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    check("en_async_rst", o_en(), 0);
    check("busy_async_rst", o_busy(), 0);
    check("data_async_rst", o_dat(), 0);
    model_reset();
    tick();
    rst_n = 1'b1;
    all_valid(48);
    for (int c = 0; c < 4; c++) tick();
    set_req(1, 1'b1, 2, 'h11);
    set_req(2, 1'b1, 6, 'h22);
    for (int c = 0; c < 24; c++) tick();
    req_valid = '0;
    for (int c = 0; c < 4; c++) tick();
    rand_run(300);
    sel = 1; nl = 6; oc = 3;
    do_reset();
    set_req(3, 1'b1, 5, 'h3C);
    tick();
    req_valid = '0;
    for (int c = 0; c < 7; c++) tick();
    set_req(0, 1'b1, 6, 'h77);
    tick();
    set_req(0, 1'b1, 7, 'h88);
    for (int c = 0; c < 6; c++) tick();
    req_valid = '0;
    for (int c = 0; c < 6; c++) tick();
    all_valid(36);
    rand_run(300);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
